// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the exhaustive truth-table sweep checker.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of input vectors in a full sweep of an n-input function.
  function automatic int unsigned vec_count(input int unsigned n);
    return 32'(1) << n;
  endfunction

endpackage

// File: rtl/tt_bin2gray.sv
// Combinational binary-to-Gray converter; used for single-bit-step sweep ordering.
module tt_bin2gray #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive sweep engine: drives every input vector, samples dut_y after LATENCY
// cycles and checks it against EXPECTED. Define TT_SWEEP_GRAY_ORDER_EN for Gray ordering.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int unsigned                     N_IN     = 4,
  parameter int unsigned                     LATENCY  = 0,
  parameter logic [vec_count(N_IN)-1:0]      EXPECTED = 16'h8000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);

  localparam int unsigned NV = vec_count(N_IN);
  localparam int unsigned CW = N_IN + 1;
  localparam int unsigned HW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [CW-1:0] LAST_VEC = CW'(NV - 1);
  localparam logic [CW-1:0] ERR_MAX  = CW'(NV);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LATENCY);

  state_t          state;
  logic [CW-1:0]   vec_cnt;
  logic [HW-1:0]   hold_cnt;

  logic            sample_c;
  logic            mismatch_c;
  logic            last_c;
  logic [CW-1:0]   vec_inc_c;
  logic [CW-1:0]   err_nxt_c;
  logic [N_IN-1:0] stim_step_c;

  // Sample/compare decode for the current RUN cycle.
  always_comb begin
    sample_c   = 1'b0;
    mismatch_c = 1'b0;
    last_c     = 1'b0;
    vec_inc_c  = vec_cnt + CW'(1);
    err_nxt_c  = err_count;
    if (state == RUN && hold_cnt == HOLD_MAX) begin
      sample_c   = 1'b1;
      mismatch_c = (dut_y != EXPECTED[stim]);
      last_c     = (vec_cnt == LAST_VEC);
    end
    if (mismatch_c && err_count != ERR_MAX) begin
      err_nxt_c = err_count + CW'(1);
    end
  end

  // Mapping from the next vector index to the stimulus actually driven.
`ifdef TT_SWEEP_GRAY_ORDER_EN
  tt_bin2gray #(
    .W(N_IN)
  ) u_bin2gray (
    .bin  (vec_inc_c[N_IN-1:0]),
    .gray (stim_step_c)
  );
`else
  assign stim_step_c = vec_inc_c[N_IN-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      vec_cnt         <= '0;
      hold_cnt        <= '0;
      stim            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          // Launch clears the previous result; stim starts at vector 0.
          if (start) begin
            state           <= RUN;
            vec_cnt         <= '0;
            hold_cnt        <= '0;
            stim            <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end
        RUN: begin
          if (sample_c) begin
            hold_cnt  <= '0;
            err_count <= err_nxt_c;
            if (mismatch_c && !first_err_valid) begin
              first_err_vec   <= stim;
              first_err_valid <= 1'b1;
            end
            if (last_c) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_nxt_c == '0);
              stim    <= '0;
              vec_cnt <= '0;
            end else begin
              vec_cnt <= vec_inc_c;
              stim    <= stim_step_c;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: three instances (latency 0, 2 and 1) checked against a sweep model.
module tb_tt_sweep_checker;

  localparam int NV     = 16;
  localparam int BUDGET = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [3];
  logic [3:0] stim  [3];
  logic       busy  [3];
  logic       done  [3];
  logic       pass  [3];
  logic       fev   [3];
  logic [4:0] errc  [3];
  logic [3:0] fvec  [3];
  logic       y0, y1, y2;
  logic       p1a, p1b, p2a, p2b;
  logic [15:0] fmask;

  int checks   = 0;
  int failures = 0;
  logic [3:0] trace [$];

  // Instance 0: combinational AND with injectable faults; 1 and 2: AND behind two registers.
  assign y0 = (&stim[0]) ^ fmask[stim[0]];
  always @(posedge clk) begin
    p1a <= &stim[1];
    p1b <= p1a;
    p2a <= &stim[2];
    p2b <= p2a;
  end
  assign y1 = p1b;
  assign y2 = p2b;

  tt_sweep_checker #(.N_IN(4), .LATENCY(0), .EXPECTED(16'h8000)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .stim(stim[0]), .dut_y(y0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
    .first_err_vec(fvec[0]), .first_err_valid(fev[0]));

  tt_sweep_checker #(.N_IN(4), .LATENCY(2), .EXPECTED(16'h8000)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .stim(stim[1]), .dut_y(y1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
    .first_err_vec(fvec[1]), .first_err_valid(fev[1]));

  tt_sweep_checker #(.N_IN(4), .LATENCY(1), .EXPECTED(16'h8000)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .stim(stim[2]), .dut_y(y2),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
    .first_err_vec(fvec[2]), .first_err_valid(fev[2]));

  // Sweep order: k-th vector presented.
  function automatic logic [3:0] ord(input int k);
`ifdef TT_SWEEP_GRAY_ORDER_EN
    return 4'(k ^ (k >> 1));
`else
    return 4'(k);
`endif
  endfunction

  // Reference: walk every RUN cycle, apply the DUT's delay, score the sampled cycles.
  task automatic model(input int lat, input int depth, input logic [15:0] m,
                       output int errs, output logic [3:0] first, output logic fv);
    logic [3:0] v, src;
    logic seen;
    errs = 0; first = 4'h0; fv = 1'b0;
    for (int c = 0; c < NV * (lat + 1); c++) begin
      if (c % (lat + 1) == lat) begin
        v    = ord(c / (lat + 1));
        src  = (c - depth < 0) ? 4'h0 : ord((c - depth) / (lat + 1));
        seen = (src == 4'hF) ^ m[src];
        if (seen != (v == 4'hF)) begin
          errs++;
          if (!fv) begin
            first = v;
            fv    = 1'b1;
          end
        end
      end
    end
  endtask

  // Launches a sweep on instance d and follows it to done, recording per-vector stim.
  task automatic run_sweep(input int d, input int lat, output int ncyc, output int bad,
                           output logic c1_clear);
    ncyc = 0; bad = 0; c1_clear = 1'b0;
    trace.delete();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1 start[d] = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (c == 0)
        c1_clear = (errc[d] == 5'd0) && !fev[d] && !pass[d] && !done[d] && busy[d];
      if (done[d]) begin
        ncyc = c + 1;
        break;
      end
      if (stim[d] !== ord(c / (lat + 1)) || busy[d] !== 1'b1) bad++;
      if (c % (lat + 1) == 0) trace.push_back(stim[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) start[i] = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({stim[i], busy[i], done[i], pass[i], errc[i], fvec[i], fev[i]} !== 17'd0) begin
          failures++;
          $display("FAIL reset inst%0d cyc%0d: outputs=%h want 0", i, cyc,
                   {stim[i], busy[i], done[i], pass[i], errc[i], fvec[i], fev[i]});
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || stim[0] !== 4'h0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b stim=%h want 0 0", busy[0], stim[0]);
    end
  endtask

  task automatic test_and_sweep();
    int ncyc, bad;
    logic c1;
    fmask = 16'h0000;
    run_sweep(0, 0, ncyc, bad, c1);
    checks++;
    if (ncyc != NV + 1) begin
      failures++;
      $display("FAIL and_latency: done at cycle %0d want %0d (0=timeout)", ncyc, NV + 1);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL and_stim_seq: bad cycles %0d want 0", bad);
    end
    checks++;
    if (pass[0] !== 1'b1 || errc[0] !== 5'd0 || fev[0] !== 1'b0) begin
      failures++;
      $display("FAIL and_result: pass=%b err=%0d fev=%b want 1 0 0", pass[0], errc[0], fev[0]);
    end
    checks++;
    if (busy[0] !== 1'b0 || stim[0] !== 4'h0) begin
      failures++;
      $display("FAIL and_done_state: busy=%b stim=%h want 0 0", busy[0], stim[0]);
    end
  endtask

  task automatic test_order();
    int ncyc, bad, steps;
    logic c1;
    fmask = 16'h0000;
    run_sweep(0, 0, ncyc, bad, c1);
    checks++;
    if (trace.size() != NV || trace[NV-1] !== ord(NV - 1)) begin
      failures++;
      $display("FAIL order_last: size=%0d last=%h want %0d %h", trace.size(),
               trace[trace.size()-1], NV, ord(NV - 1));
    end
`ifdef TT_SWEEP_GRAY_ORDER_EN
    steps = 0;
    for (int i = 1; i < trace.size(); i++)
      if ($countones(trace[i] ^ trace[i-1]) == 1) steps++;
    checks++;
    if (steps != NV - 1) begin
      failures++;
      $display("FAIL gray_one_bit: single-bit steps=%0d want %0d", steps, NV - 1);
    end
`else
    steps = 0;
`endif
  endtask

  task automatic test_fault_inject();
    int ncyc, bad, me;
    logic c1, mfv;
    logic [3:0] mfirst;
    fmask = 16'h0408;
    model(0, 0, fmask, me, mfirst, mfv);
    for (int pass_n = 0; pass_n < 2; pass_n++) begin
      run_sweep(0, 0, ncyc, bad, c1);
      checks++;
      if (errc[0] !== 5'(me) || fvec[0] !== mfirst || fev[0] !== mfv || pass[0] !== 1'b0) begin
        failures++;
        $display("FAIL fault_run%0d: err=%0d fvec=%h fev=%b pass=%b want %0d %h %b 0",
                 pass_n, errc[0], fvec[0], fev[0], pass[0], me, mfirst, mfv);
      end
      if (pass_n == 1) begin
        checks++;
        if (c1 !== 1'b1) begin
          failures++;
          $display("FAIL restart_clear: cleared=%b want 1", c1);
        end
      end
    end
  endtask

  task automatic test_pipelined();
    int ncyc, bad, me;
    logic c1, mfv;
    logic [3:0] mfirst;
    run_sweep(1, 2, ncyc, bad, c1);
    model(2, 2, 16'h0000, me, mfirst, mfv);
    checks++;
    if (ncyc != NV * 3 + 1 || bad != 0) begin
      failures++;
      $display("FAIL pipe_l2_timing: done=%0d bad=%0d want %0d 0", ncyc, bad, NV * 3 + 1);
    end
    checks++;
    if (pass[1] !== (me == 0) || errc[1] !== 5'(me)) begin
      failures++;
      $display("FAIL pipe_l2_result: pass=%b err=%0d want %b %0d", pass[1], errc[1], me == 0, me);
    end
    run_sweep(2, 1, ncyc, bad, c1);
    model(1, 2, 16'h0000, me, mfirst, mfv);
    checks++;
    if (pass[2] !== 1'b0 || errc[2] !== 5'(me) || errc[2] == 5'd0 || fvec[2] !== mfirst) begin
      failures++;
      $display("FAIL pipe_l1_short: pass=%b err=%0d fvec=%h want 0 %0d %h",
               pass[2], errc[2], fvec[2], me, mfirst);
    end
  endtask

  task automatic test_disturb();
    int ncyc, bad;
    logic c1;
    fmask = 16'h0000;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    ncyc = 0; bad = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      start[0] = (c == 5);
      if (done[0]) begin
        ncyc = c + 1;
        break;
      end
      if (stim[0] !== ord(c)) bad++;
    end
    start[0] = 1'b0;
    checks++;
    if (ncyc != NV + 1 || bad != 0 || pass[0] !== 1'b1) begin
      failures++;
      $display("FAIL start_in_run: done=%0d bad=%0d pass=%b want %0d 0 1", ncyc, bad, pass[0], NV + 1);
    end
    // Abort a sweep that already holds an error, then prove a clean rerun.
    fmask = 16'h0008;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (stim[0] !== ord(7) || errc[0] !== 5'd1) begin
      failures++;
      $display("FAIL pre_abort: stim=%h err=%0d want %h 1", stim[0], errc[0], ord(7));
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || stim[0] !== 4'h0 || errc[0] !== 5'd0 || done[0] !== 1'b0 || fev[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_sweep: busy=%b stim=%h err=%0d done=%b fev=%b want 0 0 0 0 0",
               busy[0], stim[0], errc[0], done[0], fev[0]);
    end
    fmask = 16'h0000;
    run_sweep(0, 0, ncyc, bad, c1);
    checks++;
    if (ncyc != NV + 1 || pass[0] !== 1'b1) begin
      failures++;
      $display("FAIL after_rst: done=%0d pass=%b want %0d 1", ncyc, pass[0], NV + 1);
    end
  endtask

  task automatic test_random_faults();
    int ncyc, bad, me;
    logic c1, mfv;
    logic [3:0] mfirst;
    for (int it = 0; it < 6; it++) begin
      fmask = (it == 0) ? 16'hFFFF : 16'($urandom);
      model(0, 0, fmask, me, mfirst, mfv);
      run_sweep(0, 0, ncyc, bad, c1);
      checks++;
      if (errc[0] !== 5'(me) || fev[0] !== mfv || (mfv && fvec[0] !== mfirst) ||
          pass[0] !== (me == 0) || ncyc != NV + 1) begin
        failures++;
        $display("FAIL rand_fault it%0d mask=%h: err=%0d fev=%b fvec=%h pass=%b want %0d %b %h %b",
                 it, fmask, errc[0], fev[0], fvec[0], pass[0], me, mfv, mfirst, me == 0);
      end
    end
  endtask

  initial begin
    fmask = 16'h0000;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    rst = 1'b1;
    test_reset();
    test_and_sweep();
    test_order();
    test_fault_inject();
    test_pipelined();
    test_disturb();
    test_random_faults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
